// File: rtl/frame_buf_mem_if.sv
// Write/read/clear bus of the frame buffer memory.
// The master drives strobes and addresses; the slave (memory) returns read data and status.
interface frame_buf_mem_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
);
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH/8-1:0] wr_be;
    logic                    rd_en;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic                    clr_req;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    rd_valid;
    logic                    ready;

    modport master (
        output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, clr_req,
        input  rd_data, rd_valid, ready
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, clr_req,
        output rd_data, rd_valid, ready
    );
endinterface

// File: rtl/frame_buf_mem.sv
// Line/frame storage: byte-enabled write port, 1- or 2-stage read pipeline and a
// sequential clear engine that runs after reset and on request. All strobes are active-low.
module frame_buf_mem #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 4,
    parameter int MEM_DEPTH   = 1 << ADDR_WIDTH,
    parameter int RD_LATENCY  = 1,
    parameter bit WRITE_FIRST = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    frame_buf_mem_if.slave bus
);
    localparam int NB = DATA_WIDTH / 8;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_clr_addr;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;

    logic                  w_run;
    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic                  w_clr_last;
    logic [DATA_WIDTH-1:0] w_wr_mask;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [DATA_WIDTH-1:0] w_out_data;
    logic                  w_out_vld;

    assign w_run      = (r_state == ST_RUN);
    assign w_wr_ok    = w_run && !bus.wr_en && (32'(bus.wr_addr) < MEM_DEPTH);
    assign w_rd_ok    = w_run && !bus.rd_en;
    assign w_clr_last = (r_clr_addr == ADDR_WIDTH'(MEM_DEPTH - 1));

    for (genvar gi = 0; gi < NB; gi++) begin : g_mask
        assign w_wr_mask[gi*8 +: 8] = {8{~bus.wr_be[gi]}};
    end

    // Out-of-range reads yield zero; in write-first mode a colliding write is forwarded per lane.
    always_comb begin
        w_rd_word = '0;
        if (32'(bus.rd_addr) < MEM_DEPTH)
            w_rd_word = r_mem[bus.rd_addr];
        if (WRITE_FIRST && w_wr_ok && (bus.rd_addr == bus.wr_addr))
            w_rd_word = (w_rd_word & ~w_wr_mask) | (bus.wr_data & w_wr_mask);
    end

    // Storage has no reset; the clear engine owns the write port outside RUN.
    always_ff @(posedge clk) begin
        if (!w_run)
            r_mem[r_clr_addr] <= '0;
        else if (w_wr_ok)
            r_mem[bus.wr_addr] <= (r_mem[bus.wr_addr] & ~w_wr_mask) | (bus.wr_data & w_wr_mask);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
            r_ready    <= 1'b1;
        end else if (!w_run) begin
            if (w_clr_last) begin
                r_state    <= ST_RUN;
                r_clr_addr <= '0;
                r_ready    <= 1'b0;
            end else begin
                r_clr_addr <= r_clr_addr + 1'b1;
            end
        end else if (!bus.clr_req) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
            r_ready    <= 1'b1;
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] r_p1_data;
        logic                  r_p1_vld;

        // Stage 1 keeps advancing in CLEAR so reads accepted before a clear still complete.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_p1_data <= '0;
                r_p1_vld  <= 1'b0;
            end else begin
                r_p1_vld <= w_rd_ok;
                if (w_rd_ok)
                    r_p1_data <= w_rd_word;
            end
        end

        assign w_out_vld  = r_p1_vld;
        assign w_out_data = r_p1_data;
    end else begin : g_lat1
        assign w_out_vld  = w_rd_ok;
        assign w_out_data = w_rd_word;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b1;
        end else begin
            r_rd_valid <= ~w_out_vld;
            if (w_out_vld)
                r_rd_data <= w_out_data;
        end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
    assign bus.ready    = r_ready;
endmodule

// File: tb/tb_frame_buf_mem.sv
// Bench for frame_buf_mem: two instances (full depth, latency 1, read-first; depth 12,
// latency 2, write-first) share one stimulus and are checked against a word-level model.
`timescale 1ns/1ps
module tb_frame_buf_mem;
    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          wr_en = 1'b1;
    logic          rd_en = 1'b1;
    logic          clr_req = 1'b1;
    logic [AW-1:0] wr_addr = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [1:0]    wr_be = 2'b11;

    frame_buf_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_a ();
    frame_buf_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_b ();

    assign if_a.wr_en = wr_en;   assign if_b.wr_en = wr_en;
    assign if_a.wr_addr = wr_addr; assign if_b.wr_addr = wr_addr;
    assign if_a.wr_data = wr_data; assign if_b.wr_data = wr_data;
    assign if_a.wr_be = wr_be;   assign if_b.wr_be = wr_be;
    assign if_a.rd_en = rd_en;   assign if_b.rd_en = rd_en;
    assign if_a.rd_addr = rd_addr; assign if_b.rd_addr = rd_addr;
    assign if_a.clr_req = clr_req; assign if_b.clr_req = clr_req;

    frame_buf_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(16),
                    .RD_LATENCY(1), .WRITE_FIRST(1'b0))
        u_a (.clk(clk), .reset(rst_n), .bus(if_a));
    frame_buf_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(12),
                    .RD_LATENCY(2), .WRITE_FIRST(1'b1))
        u_b (.clk(clk), .reset(rst_n), .bus(if_b));

    logic [DW-1:0] dut_data [2];
    logic          dut_valid [2];
    logic          dut_ready [2];
    assign dut_data[0] = if_a.rd_data;  assign dut_data[1] = if_b.rd_data;
    assign dut_valid[0] = if_a.rd_valid; assign dut_valid[1] = if_b.rd_valid;
    assign dut_ready[0] = if_a.ready;   assign dut_ready[1] = if_b.ready;

    always #5 clk = ~clk;

    // Reference model: word array, run flag, clear pointer and a due-time queue of reads.
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rd_t;

    logic [DW-1:0] m_mem [2][16];
    bit            m_run [2];
    int            m_clr [2];
    rd_t           q0 [$];
    rd_t           q1 [$];
    logic [DW-1:0] exp_data [2];
    logic          exp_valid [2];
    logic          exp_ready [2];
    int            edge_n = 0;
    int            checks = 0;
    int            errors = 0;

    function automatic int depth_of(int k); return (k == 0) ? 16 : 12; endfunction
    function automatic int lat_of(int k);   return (k == 0) ? 1 : 2;   endfunction
    function automatic bit wf_of(int k);    return (k == 0) ? 1'b0 : 1'b1; endfunction

    function automatic logic [DW-1:0] merge(logic [DW-1:0] old);
        logic [DW-1:0] r;
        r = old;
        if (!wr_be[0]) r[7:0]  = wr_data[7:0];
        if (!wr_be[1]) r[15:8] = wr_data[15:8];
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 1'b0; m_clr[k] = 0;
            exp_data[k] = '0; exp_valid[k] = 1'b1; exp_ready[k] = 1'b1;
        end
        q0.delete(); q1.delete();
    endtask

    task automatic model_edge(int k);
        int  d = depth_of(k);
        rd_t item;
        bit  wr_ok;
        if (m_run[k]) begin
            wr_ok = !wr_en && (int'(wr_addr) < d);
            if (!rd_en) begin
                item.due  = edge_n + lat_of(k) - 1;
                item.data = (int'(rd_addr) < d) ? m_mem[k][rd_addr] : '0;
                if (wf_of(k) && wr_ok && rd_addr == wr_addr) item.data = merge(item.data);
                if (k == 0) q0.push_back(item); else q1.push_back(item);
            end
            if (wr_ok) m_mem[k][wr_addr] = merge(m_mem[k][wr_addr]);
            if (!clr_req) begin m_run[k] = 1'b0; m_clr[k] = 0; end
        end else begin
            m_mem[k][m_clr[k]] = '0;
            if (m_clr[k] == d - 1) begin m_run[k] = 1'b1; m_clr[k] = 0; end
            else m_clr[k]++;
        end
        exp_valid[k] = 1'b1;
        if (k == 0 && q0.size() > 0 && q0[0].due == edge_n) begin
            exp_data[k] = q0[0].data; exp_valid[k] = 1'b0; void'(q0.pop_front());
        end
        if (k == 1 && q1.size() > 0 && q1[0].due == edge_n) begin
            exp_data[k] = q1[0].data; exp_valid[k] = 1'b0; void'(q1.pop_front());
        end
        exp_ready[k] = !m_run[k];
    endtask

    task automatic step();
        @(posedge clk); #1;
        edge_n++;
        if (rst_n) begin model_edge(0); model_edge(1); end
        for (int k = 0; k < 2; k++)
            if (exp_valid[k] === 1'b0) $display("rd dut%0d edge %0d data %h", k, edge_n, exp_data[k]);
    endtask

    task automatic drive(logic we, logic [AW-1:0] wa, logic [DW-1:0] wd, logic [1:0] be,
                         logic re, logic [AW-1:0] ra);
        wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_en = re; rd_addr = ra; clr_req = 1'b1;
    endtask

    task automatic idle(); drive(1'b1, '0, '0, 2'b11, 1'b1, '0); endtask

    task automatic test_reset();
        int first [2];
        idle();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({dut_ready[k], dut_valid[k], dut_data[k]} !== {exp_ready[k], exp_valid[k], exp_data[k]}) begin
                errors++;
                $display("FAIL reset_async dut%0d: got rdy=%b vld=%b data=%h want rdy=%b vld=%b data=%h",
                         k, dut_ready[k], dut_valid[k], dut_data[k], exp_ready[k], exp_valid[k], exp_data[k]);
            end
        end
        step();
        rst_n = 1'b1;
        first[0] = 0; first[1] = 0;
        for (int c = 1; c <= 40; c++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if ({dut_ready[k], dut_valid[k], dut_data[k]} !== {exp_ready[k], exp_valid[k], exp_data[k]}) begin
                    errors++;
                    $display("FAIL reset_clear dut%0d edge %0d: got rdy=%b vld=%b data=%h want rdy=%b vld=%b data=%h",
                             k, edge_n, dut_ready[k], dut_valid[k], dut_data[k], exp_ready[k], exp_valid[k], exp_data[k]);
                end
                if (first[k] == 0 && dut_ready[k] === 1'b0) first[k] = c;
            end
            if (first[0] != 0 && first[1] != 0) break;
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (first[k] != depth_of(k)) begin
                errors++;
                $display("FAIL reset_clear_len dut%0d: got %0d cycles want %0d", k, first[k], depth_of(k));
            end
        end
    endtask

    task automatic test_read_zero();
        for (int a = 0; a < 18; a++) begin
            if (a < 16) drive(1'b1, '0, '0, 2'b11, 1'b0, AW'(a)); else idle();
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if ({dut_ready[k], dut_valid[k], dut_data[k]} !== {exp_ready[k], exp_valid[k], exp_data[k]}) begin
                    errors++;
                    $display("FAIL read_zero dut%0d edge %0d: got rdy=%b vld=%b data=%h want rdy=%b vld=%b data=%h",
                             k, edge_n, dut_ready[k], dut_valid[k], dut_data[k], exp_ready[k], exp_valid[k], exp_data[k]);
                end
            end
        end
    endtask

    task automatic test_directed();
        int            xk;
        logic [DW-1:0] xv;
        for (int i = 0; i < 9; i++) begin
            case (i)
                0: drive(1'b0, 4'd3, 16'hBEEF, 2'b00, 1'b1, 4'd0);
                1: drive(1'b1, 4'd0, 16'h0000, 2'b11, 1'b0, 4'd3);
                2: drive(1'b0, 4'd5, 16'h1234, 2'b00, 1'b1, 4'd0);
                3: drive(1'b0, 4'd5, 16'hABCD, 2'b10, 1'b1, 4'd0);
                4: drive(1'b1, 4'd0, 16'h0000, 2'b11, 1'b0, 4'd5);
                5: drive(1'b0, 4'd7, 16'h1111, 2'b00, 1'b1, 4'd0);
                6: drive(1'b0, 4'd7, 16'h2222, 2'b00, 1'b0, 4'd7);
                default: idle();
            endcase
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if ({dut_ready[k], dut_valid[k], dut_data[k]} !== {exp_ready[k], exp_valid[k], exp_data[k]}) begin
                    errors++;
                    $display("FAIL directed dut%0d edge %0d: got rdy=%b vld=%b data=%h want rdy=%b vld=%b data=%h",
                             k, edge_n, dut_ready[k], dut_valid[k], dut_data[k], exp_ready[k], exp_valid[k], exp_data[k]);
                end
            end
            case (i)
                1: begin xk = 0; xv = 16'hBEEF; end
                2: begin xk = 1; xv = 16'hBEEF; end
                4: begin xk = 0; xv = 16'h12CD; end
                5: begin xk = 1; xv = 16'h12CD; end
                6: begin xk = 0; xv = 16'h1111; end
                7: begin xk = 1; xv = 16'h2222; end
                default: begin xk = -1; xv = '0; end
            endcase
            if (xk >= 0) begin
                checks++;
                if (dut_valid[xk] !== 1'b0 || dut_data[xk] !== xv) begin
                    errors++;
                    $display("FAIL directed_value dut%0d step %0d: got vld=%b data=%h want vld=0 data=%h",
                             xk, i, dut_valid[xk], dut_data[xk], xv);
                end
            end
        end
    endtask

    task automatic test_clear_req();
        int first [2];
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, AW'($urandom_range(0, 15)), DW'($urandom), 2'b00, 1'b1, '0);
            if (i == 9) begin
                drive(1'b0, 4'd2, DW'($urandom), 2'b00, 1'b0, 4'd2);
                clr_req = 1'b0;
            end
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if ({dut_ready[k], dut_valid[k], dut_data[k]} !== {exp_ready[k], exp_valid[k], exp_data[k]}) begin
                    errors++;
                    $display("FAIL clr_load dut%0d edge %0d: got rdy=%b vld=%b data=%h want rdy=%b vld=%b data=%h",
                             k, edge_n, dut_ready[k], dut_valid[k], dut_data[k], exp_ready[k], exp_valid[k], exp_data[k]);
                end
            end
        end
        first[0] = 0; first[1] = 0;
        for (int c = 1; c <= 40; c++) begin
            drive(1'b0, AW'($urandom_range(0, 15)), DW'($urandom), 2'b00, 1'b1, '0);
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if ({dut_ready[k], dut_valid[k], dut_data[k]} !== {exp_ready[k], exp_valid[k], exp_data[k]}) begin
                    errors++;
                    $display("FAIL clr_window dut%0d edge %0d: got rdy=%b vld=%b data=%h want rdy=%b vld=%b data=%h",
                             k, edge_n, dut_ready[k], dut_valid[k], dut_data[k], exp_ready[k], exp_valid[k], exp_data[k]);
                end
                if (first[k] == 0 && dut_ready[k] === 1'b0) first[k] = c;
            end
            if (first[0] != 0 && first[1] != 0) break;
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (first[k] != depth_of(k)) begin
                errors++;
                $display("FAIL clr_len dut%0d: got %0d cycles want %0d", k, first[k], depth_of(k));
            end
        end
        idle();
        test_read_zero();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)));
            clr_req = ($urandom_range(0, 63) != 0);
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if ({dut_ready[k], dut_valid[k], dut_data[k]} !== {exp_ready[k], exp_valid[k], exp_data[k]}) begin
                    errors++;
                    $display("FAIL random dut%0d edge %0d: got rdy=%b vld=%b data=%h want rdy=%b vld=%b data=%h",
                             k, edge_n, dut_ready[k], dut_valid[k], dut_data[k], exp_ready[k], exp_valid[k], exp_data[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int first [2];
        for (int pass = 0; pass < 2; pass++) begin
            idle();
            if (pass == 0) begin
                clr_req = 1'b0;
                step();
                clr_req = 1'b1;
                for (int c = 0; c < 20 && m_clr[0] != 9; c++) step();
            end else begin
                drive(1'b1, '0, '0, 2'b11, 1'b0, 4'd3);
                step();
                rd_addr = 4'd5;
                step();
            end
            rst_n = 1'b0;
            idle();
            model_reset();
            #1;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if ({dut_ready[k], dut_valid[k], dut_data[k]} !== {exp_ready[k], exp_valid[k], exp_data[k]}) begin
                    errors++;
                    $display("FAIL reset_mid%0d dut%0d: got rdy=%b vld=%b data=%h want rdy=%b vld=%b data=%h",
                             pass, k, dut_ready[k], dut_valid[k], dut_data[k], exp_ready[k], exp_valid[k], exp_data[k]);
                end
            end
            step();
            rst_n = 1'b1;
            first[0] = 0; first[1] = 0;
            for (int c = 1; c <= 40; c++) begin
                step();
                for (int k = 0; k < 2; k++) begin
                    checks++;
                    if ({dut_ready[k], dut_valid[k], dut_data[k]} !== {exp_ready[k], exp_valid[k], exp_data[k]}) begin
                        errors++;
                        $display("FAIL reset_mid%0d_clear dut%0d edge %0d: got rdy=%b vld=%b data=%h want rdy=%b vld=%b data=%h",
                                 pass, k, edge_n, dut_ready[k], dut_valid[k], dut_data[k], exp_ready[k], exp_valid[k], exp_data[k]);
                    end
                    if (first[k] == 0 && dut_ready[k] === 1'b0) first[k] = c;
                end
                if (first[0] != 0 && first[1] != 0) break;
            end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (first[k] != depth_of(k)) begin
                    errors++;
                    $display("FAIL reset_mid%0d_len dut%0d: got %0d cycles want %0d", pass, k, first[k], depth_of(k));
                end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read_zero();
        test_directed();
        test_clear_req();
        test_random();
        test_reset_mid();
        test_read_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
